register_file: RTL and testbench

Parametrised multi-entry register storage for the MIPS datapath. It generalises the single load-enabled register into a file of 2^ADDR_W entries with two independent combinational read ports, one synchronous write port with per-byte lane enables, an optional hardwired-zero entry 0, and optional same-cycle write-to-read bypass. It sits between instruction decode (read addresses) and write-back (write port), and serves as the architectural GPR file.

---
 rtl/register_file.sv | 104 ++++++++++
 tb/tb_register_file.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Multi-entry register storage used as the architectural GPR file of the MIPS
// datapath. 2^ADDR_W entries of WIDTH bits, two independent combinational read
// ports, one synchronous write port with per-byte lane enables, an optional
// hardwired-zero entry 0 and an optional same-cycle write-to-read bypass.
//
// Parameters:
//   WIDTH    data width in bits (multiple of 8); NB = WIDTH/8 byte lanes
//   ADDR_W   address width; depth = 2^ADDR_W
//   ZERO_REG 1: entry 0 reads 0 and ignores writes; 0: ordinary entry
//   BYPASS   1: a read of the entry being written returns the merged new value
//            0: reads return stored contents only
//
// Ports:
//   clk             clock; writes land on the rising edge
//   rst             asynchronous, active-high; clears every entry
//   we/waddr/wdata  write enable, address, data
//   wbe             byte-lane enables, bit i covers wdata[8i+7:8i]
//   raddr1/rdata1   read port 1 (combinational)
//   raddr2/rdata2   read port 2 (combinational)
// -----------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wbe,
    input  logic [ADDR_W-1:0]     raddr1,
    output logic [WIDTH-1:0]      rdata1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [WIDTH-1:0]      rdata2
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_active;

    // A write to entry 0 is discarded when it is hardwired to zero, so it must
    // neither reach storage nor be bypassed to a reader.
    always_comb begin
        wr_active = we && !((ZERO_REG != 0) && (waddr == '0));
    end

    // Next-state of the array: only the addressed entry changes, and only in
    // the enabled byte lanes. This is also the bypass source, since the
    // merged value of the written entry is exactly mem_d[waddr].
    always_comb begin
        mem_d = mem_q;
        if (wr_active) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port 1. Reset forces 0 (which also suppresses bypass); with BYPASS
    // the read comes from mem_d, which differs from mem_q only at a live write.
    always_comb begin
        if (rst) begin
            rdata1 = '0;
        end else if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (BYPASS != 0) begin
            rdata1 = mem_d[raddr1];
        end else begin
            rdata1 = mem_q[raddr1];
        end
    end

    // Read port 2, identical to port 1 and fully independent of it.
    always_comb begin
        if (rst) begin
            rdata2 = '0;
        end else if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (BYPASS != 0) begin
            rdata2 = mem_d[raddr2];
        end else begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Drives two register files from the same stimulus: dut_a with the default
// configuration (ZERO_REG=1, BYPASS=1) and dut_b with ZERO_REG=0, BYPASS=0.
// A behavioural model (plain arrays) predicts every read; a compare process
// checks all four read ports on each falling edge, and directed sections pin
// hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NB = W / 8;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [NB-1:0] wbe;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [W-1:0]  rdata1_a, rdata2_a, rdata1_b, rdata2_b;

    register_file #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr1(raddr1), .rdata1(rdata1_a), .raddr2(raddr2), .rdata2(rdata2_a)
    );

    register_file #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%08h expected=%08h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: one plain array per configuration.
    logic [W-1:0] model_a [32];
    logic [W-1:0] model_b [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                model_a[k] = '0;
                model_b[k] = '0;
            end
        end else if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    if (waddr != 0) model_a[waddr][8*i +: 8] = wdata[8*i +: 8];
                    model_b[waddr][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    // Expected read value for configuration a (which_b=0) or b (which_b=1).
    function automatic logic [W-1:0] exp_rd(input bit which_b, input logic [AW-1:0] addr);
        logic [W-1:0] v;
        if (rst) return '0;
        if (!which_b && addr == 0) return '0;
        v = which_b ? model_b[addr] : model_a[addr];
        if (!which_b && we && addr == waddr) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) v[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return v;
    endfunction

    // Compare process: all ports against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_a_rd1", rdata1_a, exp_rd(1'b0, raddr1));
        check("cmp_a_rd2", rdata2_a, exp_rd(1'b0, raddr2));
        check("cmp_b_rd1", rdata1_b, exp_rd(1'b1, raddr1));
        check("cmp_b_rd2", rdata2_b, exp_rd(1'b1, raddr2));
    end

    // driver tasks
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [NB-1:0] be, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        we = w; waddr = wa; wdata = wd; wbe = be; raddr1 = r1; raddr2 = r2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            model_a[k] = '0;
            model_b[k] = '0;
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0);
        next_cycle();
        next_cycle();
        check("rst_hold_a_rd1", rdata1_a, 32'h0);
        check("rst_hold_b_rd2", rdata2_b, 32'h0);
        rst = 1'b0;

        // Reset sweep: every entry reads 0.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, '0, '0, '0, AW'(a), AW'(31 - a));
            settle();
            check("rst_sweep_b_rd1", rdata1_b, 32'h0);
            check("rst_sweep_b_rd2", rdata2_b, 32'h0);
            next_cycle();
        end

        // Full write and hold.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("full_a_rd1", rdata1_a, 32'hDEADBEEF);
            check("full_b_rd2", rdata2_b, 32'hDEADBEEF);
            next_cycle();
        end

        // we with all lanes disabled is a no-op.
        drive(1'b1, 5'd5, 32'h01234567, 4'h0, 5'd5, 5'd5);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
        settle();
        check("nolane_a_rd1", rdata1_a, 32'hDEADBEEF);
        next_cycle();

        // Byte-lane writes.
        drive(1'b1, 5'd5, 32'h0000BABE, 4'b0011, 5'd5, 5'd5);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
        settle();
        check("lane_lo_a_rd1", rdata1_a, 32'hDEADBABE);
        check("lane_lo_b_rd1", rdata1_b, 32'hDEADBABE);
        next_cycle();
        drive(1'b1, 5'd5, 32'h11000000, 4'b1000, 5'd5, 5'd5);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
        settle();
        check("lane_hi_a_rd2", rdata2_a, 32'h11ADBABE);
        check("lane_hi_b_rd2", rdata2_b, 32'h11ADBABE);
        next_cycle();

        // Zero register.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
        settle();
        check("zero_wr_a_rd1", rdata1_a, 32'h0);
        check("zero_wr_a_rd2", rdata2_a, 32'h0);
        check("zero_wr_b_rd1", rdata1_b, 32'h0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
        settle();
        check("zero_after_a_rd1", rdata1_a, 32'h0);
        check("zero_after_b_rd1", rdata1_b, 32'hFFFFFFFF);
        check("zero_after_b_rd2", rdata2_b, 32'hFFFFFFFF);
        next_cycle();

        // Bypass.
        drive(1'b1, 5'd7, 32'h12345678, 4'hF, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd7, 32'hCAFEF00D, 4'b0101, 5'd7, 5'd7);
        settle();
        check("byp_a_rd1", rdata1_a, 32'h12FE560D);
        check("byp_a_rd2", rdata2_a, 32'h12FE560D);
        check("byp_b_rd1", rdata1_b, 32'h12345678);
        check("byp_b_rd2", rdata2_b, 32'h12345678);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
        settle();
        check("byp_after_a_rd1", rdata1_a, 32'h12FE560D);
        check("byp_after_b_rd2", rdata2_b, 32'h12FE560D);
        next_cycle();

        // Reset mid-operation, raised between edges.
        drive(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd3, 32'h1111BABE, 4'hF, 5'd3, 5'd3);
        settle();
        check("pre_rst_a_rd1", rdata1_a, 32'h1111BABE);
        check("pre_rst_b_rd1", rdata1_b, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("async_rst_a_rd1", rdata1_a, 32'h0);
        check("async_rst_b_rd1", rdata1_b, 32'h0);
        next_cycle();
        rst = 1'b0;
        we  = 1'b0;
        settle();
        check("post_rst_a_rd1", rdata1_a, 32'h0);
        check("post_rst_b_rd1", rdata1_b, 32'h0);
        next_cycle();

        // Randomized traffic with collisions and occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] wa;
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, wa, $urandom, NB'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, 31)));
            rst = ($urandom_range(0, 59) == 0);
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
